prio_enc_queue: RTL

- Parametrised, registered successor to the team's 8:3 enable-gated priority encoder.
- Latches one-cycle request pulses from N sources into a sticky pending vector.
- Issues one encoded index per grant through a valid/ready output slot, so no request is lost when the consumer stalls.
- Supports fixed-priority (MSB wins) or round-robin selection; sits between interrupt/event sources and a single sequential consumer.

---
 rtl/prio_pkg.sv | 17 +
 rtl/prio_sel.sv | 53 +++++
 rtl/prio_enc_queue.sv | 94 +++++++++
 3 files changed

// File: rtl/prio_pkg.sv
`default_nettype none
// ============================================================================
//  prio_pkg
//  Shared selection-mode constants and width helper for the priority blocks.
//  Revision: 1.0
// ============================================================================
package prio_pkg;

   localparam int PRIO_FIXED = 0;
   localparam int PRIO_RR    = 1;

   function automatic int idx_w(input int n);
      return $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/prio_sel.sv
`default_nettype none
// ============================================================================
//  prio_sel
//  Combinational selector: highest set bit, or cyclic-downward scan from ptr.
//  Revision: 1.0
// ============================================================================
module prio_sel
   import prio_pkg::*;
#(
   parameter  int N = 8,
   localparam int W = idx_w(N)
) (
   input  logic [N-1:0] cand,
   input  logic [W-1:0] ptr,
   input  logic         mode,
   output logic [W-1:0] sel,
   output logic         any
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [W-1:0]   hi_fixed;
   logic [W-1:0]   hi_rot;
   logic [W:0]     rr_sum;

   assign any = |cand;
   assign dbl = {cand, cand};

   // Rotate so that bit ptr lands on the MSB; the highest set bit of rot is
   // then the first hit of the downward scan starting at ptr.
   assign rot = N'(dbl >> ({1'b0, ptr} + (W+1)'(1)));

   always_comb begin
      hi_fixed = '0;
      hi_rot   = '0;
      for (int i = 0; i < N; i++) begin
         if (cand[i]) hi_fixed = W'(i);
         if (rot[i])  hi_rot   = W'(i);
      end
   end

   // Undo the rotation: original index = (pos + ptr + 1) mod N.
   always_comb begin
      rr_sum = {1'b0, hi_rot} + {1'b0, ptr} + (W+1)'(1);
      if (rr_sum >= (W+1)'(N)) begin
         rr_sum = rr_sum - (W+1)'(N);
      end
   end

   assign sel = mode ? rr_sum[W-1:0] : hi_fixed;

endmodule
`default_nettype wire

// File: rtl/prio_enc_queue.sv
`default_nettype none
// ============================================================================
//  prio_enc_queue
//  Sticky request capture with one registered grant slot (valid/ready).
//  Revision: 1.0
// ============================================================================
module prio_enc_queue
   import prio_pkg::*;
#(
   parameter  int N    = 8,
   parameter  int MODE = PRIO_FIXED,
   localparam int W    = idx_w(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         flush,
   input  logic [N-1:0] req,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_idx,
   output logic [N-1:0] pending,
   output logic         busy
);

   localparam logic [W-1:0] PTR_INIT = W'(N - 1);
   localparam logic         IS_RR    = (MODE == PRIO_RR);

   logic [N-1:0] cand;
   logic         slot_free;
   logic         load;
   logic         any;
   logic [W-1:0] sel;
   logic [W-1:0] ptr;
   logic [N-1:0] sel_onehot;
   logic [N-1:0] pending_nxt;
   logic         valid_nxt;
   logic [W-1:0] idx_nxt;
   logic [W-1:0] ptr_nxt;

   assign cand       = pending | req;
   assign slot_free  = !out_valid || out_ready;
   assign load       = en && slot_free && any && !flush;
   assign sel_onehot = N'(1) << sel;

   prio_sel #(
      .N (N)
   ) u_sel (
      .cand (cand),
      .ptr  (ptr),
      .mode (IS_RR),
      .sel  (sel),
      .any  (any)
   );

   always_comb begin
      pending_nxt = cand;
      valid_nxt   = out_valid;
      idx_nxt     = out_idx;
      ptr_nxt     = ptr;
      if (flush) begin
         pending_nxt = '0;
         valid_nxt   = 1'b0;
      end else if (load) begin
         // A request arriving on the granted bit in this cycle is consumed here.
         pending_nxt = cand & ~sel_onehot;
         valid_nxt   = 1'b1;
         idx_nxt     = sel;
         if (IS_RR) begin
            ptr_nxt = (sel == '0) ? PTR_INIT : sel - W'(1);
         end
      end else if (out_valid && out_ready) begin
         valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending   <= '0;
         out_valid <= 1'b0;
         out_idx   <= '0;
         ptr       <= PTR_INIT;
         busy      <= 1'b0;
      end else begin
         pending   <= pending_nxt;
         out_valid <= valid_nxt;
         out_idx   <= idx_nxt;
         ptr       <= ptr_nxt;
         busy      <= valid_nxt | (|pending_nxt);
      end
   end

endmodule
`default_nettype wire
